// File: rtl/sprite_pkg.sv
// Shared constants, FSM state type and slot record for the sprite line evaluator.
package sprite_pkg;
    localparam int NUM_SPR = 32;
    localparam int SLOTS   = 4;
    localparam int SPR_H   = 16;
    localparam int ID_W    = 5;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int ROW_W   = 4;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    typedef struct packed {
        logic             valid;
        logic [ID_W-1:0]  id;
        logic [X_W-1:0]   x;
        logic [ROW_W-1:0] row;
    } slot_t;
endpackage

// File: rtl/sprite_table_if.sv
// Sprite write port, scanline request and per-slot scanline results.
interface sprite_table_if #(parameter int SLOTS = sprite_pkg::SLOTS);
    logic                              sprite_pos;
    logic                              sprite_attr;
    logic [sprite_pkg::ID_W-1:0]       sprite_sel;
    logic [sprite_pkg::X_W-1:0]        sprite_x;
    logic [sprite_pkg::Y_W-1:0]        sprite_y;
    logic                              sprite_vis;
    logic                              line_start;
    logic [sprite_pkg::Y_W-1:0]        line_y;
    logic [SLOTS-1:0]                  slot_valid;
    logic [sprite_pkg::ID_W*SLOTS-1:0] slot_id;
    logic [sprite_pkg::X_W*SLOTS-1:0]  slot_x;
    logic [sprite_pkg::ROW_W*SLOTS-1:0] slot_row;
    logic                              overflow;
    logic                              scan_done;

    modport master (
        output sprite_pos, sprite_attr, sprite_sel, sprite_x, sprite_y, sprite_vis,
               line_start, line_y,
        input  slot_valid, slot_id, slot_x, slot_row, overflow, scan_done
    );

    modport slave (
        input  sprite_pos, sprite_attr, sprite_sel, sprite_x, sprite_y, sprite_vis,
               line_start, line_y,
        output slot_valid, slot_id, slot_x, slot_row, overflow, scan_done
    );
endinterface

// File: rtl/sprite_line_match.sv
// Combinational hit rule: sprite covers the line when visible and 0 <= line - y < SPR_H.
module sprite_line_match #(
    parameter int SPR_H = sprite_pkg::SPR_H
) (
    input  logic [sprite_pkg::Y_W-1:0]   line,
    input  logic [sprite_pkg::Y_W-1:0]   y,
    input  logic                         vis,
    output logic                         hit,
    output logic [sprite_pkg::ROW_W-1:0] row
);
    import sprite_pkg::*;

    // One extra bit so a sprite below the line shows up as negative instead of wrapping.
    logic [Y_W:0] d;

    assign d   = {1'b0, line} - {1'b0, y};
    assign hit = vis && !d[Y_W] && (d < (Y_W+1)'(SPR_H));
    assign row = d[ROW_W-1:0];
endmodule

// File: rtl/sprite_table.sv
// Sprite attribute table with a sequential scanline evaluator reporting up to SLOTS hits per line.
module sprite_table #(
    parameter int NUM_SPR = sprite_pkg::NUM_SPR,
    parameter int SLOTS   = sprite_pkg::SLOTS,
    parameter int SPR_H   = sprite_pkg::SPR_H
) (
    input  logic         clk,
    input  logic         reset,
    sprite_table_if.slave bus
);
    import sprite_pkg::*;

    localparam int IDX_W = $clog2(NUM_SPR);
    localparam int CNT_W = $clog2(SLOTS + 1);
    localparam int SL_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    state_t           state_q, state_d;
    logic [X_W-1:0]   x_mem   [NUM_SPR];
    logic [Y_W-1:0]   y_mem   [NUM_SPR];
    logic             vis_mem [NUM_SPR];
    logic [Y_W-1:0]   line_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;
    slot_t            shadow_q [SLOTS];
    logic             shadow_ovf_q;
    slot_t            out_q [SLOTS];
    logic             ovf_q;
    logic             hit;
    logic [ROW_W-1:0] row;

    sprite_line_match #(.SPR_H(SPR_H)) u_match (
        .line (line_q),
        .y    (y_mem[idx_q]),
        .vis  (vis_mem[idx_q]),
        .hit  (hit),
        .row  (row)
    );

    // NOTE: the table is cleared by reset because software relies on all sprites
    // starting invisible; this is a deliberate flop array, not an SRAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                x_mem[i]   <= '0;
                y_mem[i]   <= '0;
                vis_mem[i] <= 1'b0;
            end
        end else begin
            // NOTE: non-blocking writes mean the entry under examination this cycle
            // still presents its old value to the hit check.
            if (bus.sprite_pos) begin
                x_mem[bus.sprite_sel] <= bus.sprite_x;
                y_mem[bus.sprite_sel] <= bus.sprite_y;
            end
            if (bus.sprite_attr) vis_mem[bus.sprite_sel] <= bus.sprite_vis;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: state_d gets its default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (bus.line_start) begin
            state_d = SCAN;
        end else begin
            unique case (state_q)
                IDLE:    state_d = IDLE;
                SCAN:    if (idx_q == IDX_W'(NUM_SPR - 1)) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_q       <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            shadow_ovf_q <= 1'b0;
            ovf_q        <= 1'b0;
            for (int s = 0; s < SLOTS; s++) begin
                shadow_q[s] <= '0;
                out_q[s]    <= '0;
            end
        end else if (bus.line_start) begin
            line_q       <= bus.line_y;
            idx_q        <= '0;
            cnt_q        <= '0;
            shadow_ovf_q <= 1'b0;
            for (int s = 0; s < SLOTS; s++) shadow_q[s] <= '0;
        end else if (state_q == SCAN) begin
            if (hit) begin
                if (cnt_q < CNT_W'(SLOTS)) begin
                    shadow_q[cnt_q[SL_W-1:0]] <= '{valid: 1'b1, id: ID_W'(idx_q),
                                                   x: x_mem[idx_q], row: row};
                    cnt_q <= cnt_q + 1'b1;
                end else begin
                    shadow_ovf_q <= 1'b1;
                end
            end
            idx_q <= idx_q + 1'b1;
        end else if (state_q == DONE) begin
            out_q <= shadow_q;
            ovf_q <= shadow_ovf_q;
        end
    end

    // A restart landing on DONE cancels the copy, so it must not announce one either.
    assign bus.scan_done = (state_q == DONE) && !bus.line_start;
    assign bus.overflow  = ovf_q;

    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
        assign bus.slot_valid[s]                = out_q[s].valid;
        assign bus.slot_id[s*ID_W +: ID_W]      = out_q[s].id;
        assign bus.slot_x[s*X_W +: X_W]         = out_q[s].x;
        assign bus.slot_row[s*ROW_W +: ROW_W]   = out_q[s].row;
    end
endmodule

// File: tb/tb_sprite_table.sv
// Directed bench for sprite_table: single hit, overflow, line boundaries, restart, write races, reset.
module tb_sprite_table;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_cnt = 0;

    sprite_table_if #(.SLOTS(4)) bus ();

    sprite_table dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.scan_done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic wr(input logic [4:0] sel, input logic [9:0] x, input logic [8:0] y,
                      input logic v, input logic pos, input logic attr);
        bus.sprite_sel  = sel;
        bus.sprite_x    = x;
        bus.sprite_y    = y;
        bus.sprite_vis  = v;
        bus.sprite_pos  = pos;
        bus.sprite_attr = attr;
        tick();
        bus.sprite_pos  = 1'b0;
        bus.sprite_attr = 1'b0;
    endtask

    task automatic start_line(input logic [8:0] ly);
        bus.line_y     = ly;
        bus.line_start = 1'b1;
        tick();
        bus.line_start = 1'b0;
    endtask

    // Cycle numbers are relative to the cycle that carried line_start (cycle 0).
    task automatic wait_done(input int start, output int cyc);
        cyc = start;
        while (bus.scan_done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        if (bus.scan_done !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL scan_done_timeout: no pulse within %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.slot_valid !== 4'b0) begin n_fail++; $display("FAIL reset_valid: got %0h expected 0", bus.slot_valid); end
        n_checks++; if (bus.slot_id !== 20'h0) begin n_fail++; $display("FAIL reset_id: got %0h expected 0", bus.slot_id); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b expected 0", bus.overflow); end
        n_checks++; if (bus.scan_done !== 1'b0) begin n_fail++; $display("FAIL reset_scan_done: got %0b expected 0", bus.scan_done); end
    endtask

    task automatic test_single();
        int c;
        do_reset();
        wr(5'd3, 10'd100, 9'd50, 1'b1, 1'b1, 1'b1);
        start_line(9'd55);
        wait_done(1, c);
        n_checks++; if (c != 33) begin n_fail++; $display("FAIL single_latency: got %0d expected 33", c); end
        tick();
        n_checks++; if (bus.slot_valid !== 4'b0001) begin n_fail++; $display("FAIL single_valid: got %0h expected 1", bus.slot_valid); end
        n_checks++; if (bus.slot_id !== 20'h00003) begin n_fail++; $display("FAIL single_id: got %0h expected 3", bus.slot_id); end
        n_checks++; if (bus.slot_x !== 40'd100) begin n_fail++; $display("FAIL single_x: got %0h expected 64", bus.slot_x); end
        n_checks++; if (bus.slot_row !== 16'h0005) begin n_fail++; $display("FAIL single_row: got %0h expected 5", bus.slot_row); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL single_overflow: got %0b expected 0", bus.overflow); end
        repeat (10) tick();
        n_checks++; if (bus.slot_id !== 20'h00003 || bus.slot_valid !== 4'b0001) begin n_fail++; $display("FAIL single_hold: got id %0h valid %0h expected 3/1", bus.slot_id, bus.slot_valid); end
    endtask

    task automatic test_overflow();
        int c;
        do_reset();
        wr(5'd1,  10'd10,  9'd10, 1'b1, 1'b1, 1'b1);
        wr(5'd2,  10'd20,  9'd10, 1'b1, 1'b1, 1'b0);
        wr(5'd4,  10'd40,  9'd10, 1'b1, 1'b1, 1'b1);
        wr(5'd7,  10'd70,  9'd10, 1'b1, 1'b1, 1'b1);
        wr(5'd9,  10'd90,  9'd10, 1'b1, 1'b1, 1'b1);
        wr(5'd20, 10'd200, 9'd10, 1'b1, 1'b1, 1'b1);
        wr(5'd31, 10'd310, 9'd10, 1'b0, 1'b1, 1'b0);
        wr(5'd31, 10'd0,   9'd0,  1'b1, 1'b0, 1'b1);
        start_line(9'd12);
        wait_done(1, c);
        tick();
        n_checks++; if (bus.slot_valid !== 4'hF) begin n_fail++; $display("FAIL ovf_valid: got %0h expected f", bus.slot_valid); end
        n_checks++; if (bus.slot_id !== {5'd9, 5'd7, 5'd4, 5'd1}) begin n_fail++; $display("FAIL ovf_id: got %0h expected %0h", bus.slot_id, {5'd9, 5'd7, 5'd4, 5'd1}); end
        n_checks++; if (bus.slot_x !== {10'd90, 10'd70, 10'd40, 10'd10}) begin n_fail++; $display("FAIL ovf_x: got %0h expected %0h", bus.slot_x, {10'd90, 10'd70, 10'd40, 10'd10}); end
        n_checks++; if (bus.slot_row !== 16'h2222) begin n_fail++; $display("FAIL ovf_row: got %0h expected 2222", bus.slot_row); end
        n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b expected 1", bus.overflow); end
        start_line(9'd100);
        wait_done(1, c);
        tick();
        n_checks++; if (bus.overflow !== 1'b0 || bus.slot_valid !== 4'h0) begin n_fail++; $display("FAIL ovf_clear: got ovf %0b valid %0h expected 0/0", bus.overflow, bus.slot_valid); end
    endtask

    task automatic test_boundary();
        int c;
        do_reset();
        wr(5'd0, 10'd1, 9'd470, 1'b1, 1'b1, 1'b1);
        wr(5'd1, 10'd2, 9'd479, 1'b1, 1'b1, 1'b1);
        wr(5'd2, 10'd3, 9'd464, 1'b1, 1'b1, 1'b1);
        wr(5'd3, 10'd4, 9'd463, 1'b1, 1'b1, 1'b1);
        start_line(9'd479);
        wait_done(1, c);
        tick();
        n_checks++; if (bus.slot_valid !== 4'b0111) begin n_fail++; $display("FAIL bnd_valid: got %0h expected 7", bus.slot_valid); end
        n_checks++; if (bus.slot_id !== {5'd0, 5'd2, 5'd1, 5'd0}) begin n_fail++; $display("FAIL bnd_id: got %0h expected %0h", bus.slot_id, {5'd0, 5'd2, 5'd1, 5'd0}); end
        n_checks++; if (bus.slot_row !== 16'h0F09) begin n_fail++; $display("FAIL bnd_row: got %0h expected f09", bus.slot_row); end
        start_line(9'd5);
        wait_done(1, c);
        tick();
        n_checks++; if (bus.slot_valid !== 4'b0 || bus.slot_id !== 20'h0 || bus.slot_x !== 40'h0) begin n_fail++; $display("FAIL bnd_nowrap: got valid %0h id %0h x %0h expected 0", bus.slot_valid, bus.slot_id, bus.slot_x); end
    endtask

    task automatic test_restart();
        int c;
        int d0;
        do_reset();
        wr(5'd6, 10'd7, 9'd20, 1'b1, 1'b1, 1'b1);
        wr(5'd8, 10'd9, 9'd55, 1'b1, 1'b1, 1'b1);
        start_line(9'd20);
        wait_done(1, c);
        tick();
        n_checks++; if (bus.slot_id !== 20'h00006) begin n_fail++; $display("FAIL rst_first_id: got %0h expected 6", bus.slot_id); end
        start_line(9'd20);
        repeat (9) tick();
        d0 = done_cnt;
        start_line(9'd60);
        n_checks++; if (bus.slot_id !== 20'h00006 || bus.slot_valid !== 4'b0001) begin n_fail++; $display("FAIL rst_hold: got id %0h valid %0h expected 6/1", bus.slot_id, bus.slot_valid); end
        wait_done(1, c);
        n_checks++; if (c != 33) begin n_fail++; $display("FAIL rst_latency: got %0d expected 33", c); end
        tick();
        n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL rst_done_count: got %0d expected 1", done_cnt - d0); end
        n_checks++; if (bus.slot_id !== 20'h00008 || bus.slot_row !== 16'h0005 || bus.slot_x !== 40'd9) begin n_fail++; $display("FAIL rst_result: got id %0h row %0h x %0h expected 8/5/9", bus.slot_id, bus.slot_row, bus.slot_x); end
        repeat (40) tick();
        n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL rst_no_extra: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_write_during_scan();
        int c;
        do_reset();
        wr(5'd0, 10'd20, 9'd100, 1'b0, 1'b1, 1'b1);
        wr(5'd5, 10'd50, 9'd100, 1'b1, 1'b1, 1'b1);
        start_line(9'd100);
        repeat (2) tick();
        wr(5'd0, 10'd0, 9'd0, 1'b1, 1'b0, 1'b1);
        repeat (2) tick();
        wr(5'd5, 10'd0, 9'd0, 1'b0, 1'b0, 1'b1);
        wait_done(7, c);
        tick();
        n_checks++; if (bus.slot_valid !== 4'b0001 || bus.slot_id !== 20'h00005 || bus.slot_x !== 40'd50) begin n_fail++; $display("FAIL race_line1: got valid %0h id %0h x %0h expected 1/5/32", bus.slot_valid, bus.slot_id, bus.slot_x); end
        start_line(9'd100);
        wait_done(1, c);
        tick();
        n_checks++; if (bus.slot_valid !== 4'b0001 || bus.slot_id !== 20'h00000 || bus.slot_x !== 40'd20) begin n_fail++; $display("FAIL race_line2: got valid %0h id %0h x %0h expected 1/0/14", bus.slot_valid, bus.slot_id, bus.slot_x); end
    endtask

    task automatic test_reset_mid_scan();
        int c;
        int d0;
        start_line(9'd100);
        repeat (14) tick();
        n_checks++; if (bus.slot_valid !== 4'b0001) begin n_fail++; $display("FAIL mid_pre_valid: got %0h expected 1", bus.slot_valid); end
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        n_checks++; if (bus.slot_valid !== 4'b0 || bus.slot_x !== 40'h0 || bus.overflow !== 1'b0 || bus.scan_done !== 1'b0) begin n_fail++; $display("FAIL mid_clear: got valid %0h x %0h ovf %0b done %0b expected 0", bus.slot_valid, bus.slot_x, bus.overflow, bus.scan_done); end
        tick();
        tick();
        reset = 1'b1;
        repeat (40) tick();
        n_checks++; if (done_cnt != d0) begin n_fail++; $display("FAIL mid_no_done: got %0d pulses expected 0", done_cnt - d0); end
        start_line(9'd100);
        wait_done(1, c);
        n_checks++; if (c != 33) begin n_fail++; $display("FAIL mid_latency: got %0d expected 33", c); end
        tick();
        n_checks++; if (bus.slot_valid !== 4'b0) begin n_fail++; $display("FAIL mid_table_cleared: got %0h expected 0", bus.slot_valid); end
    endtask

    initial begin
        bus.sprite_pos  = 1'b0;
        bus.sprite_attr = 1'b0;
        bus.sprite_sel  = '0;
        bus.sprite_x    = '0;
        bus.sprite_y    = '0;
        bus.sprite_vis  = 1'b0;
        bus.line_start  = 1'b0;
        bus.line_y      = '0;
        test_reset();
        test_single();
        test_overflow();
        test_boundary();
        test_restart();
        test_write_during_scan();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
